// File: rtl/scroll_hex_disp.sv
// Scrolling hex display: shows a DIGITS-wide circular window of a NIBBLES-digit word on a
// multiplexed active-low 7-segment display. Optional auto-scroll is enabled by `SCROLL_AUTO_EN.
module scroll_hex_disp #(
    parameter int NIBBLES         = 8,
    parameter int DIGITS          = 4,
    parameter int REFRESH_BITS    = 17,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*NIBBLES-1:0]       value,
    input  logic                       btnU,
    input  logic                       btnD,
    input  logic                       auto_en,
    output logic [6:0]                 seg,
    output logic [DIGITS-1:0]          an,
    output logic [$clog2(NIBBLES)-1:0] pos
);

    localparam int PW = $clog2(NIBBLES);
    localparam int DW = $clog2(DIGITS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Button bit 0 = up, bit 1 = down throughout.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         armed_q, armed_d;
    logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]         db_ref;
    logic [1:0]         press;

    logic [PW-1:0]           pos_q, pos_d;
    logic                    step_up, step_dn;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [PW:0]             nib_sum, nib_full;
    logic [3:0]              nib;
    logic [6:0]              seg_q, seg_d;
    logic [DIGITS-1:0]       an_q, an_d;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // NOTE: synchronizer flops carry no reset so they keep tracking a button held during reset.
    always_ff @(posedge clk) begin
        sync1_q <= {btnD, btnU};
        sync2_q <= sync1_q;
    end

    // Until a debounced release is seen after reset, the debouncer behaves as if the button
    // were already pressed, so a press held through reset cannot fire.
    assign db_ref = lvl_q | ~armed_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        lvl_d    = lvl_q;
        armed_d  = armed_q;
        db_cnt_d = '0;
        press    = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != db_ref[b]) begin
                if (db_cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[b]   = sync2_q[b];
                    armed_d[b] = 1'b1;
                    press[b]   = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + CW'(1);
                end
            end
        end
    end

`ifdef SCROLL_AUTO_EN
    localparam int AW = $clog2(AUTO_DIV + 1);
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_tick;
`else
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
`endif

    always_comb begin
        pos_d   = pos_q;
        step_up = press[0] & ~press[1];
        step_dn = press[1] & ~press[0];
`ifdef SCROLL_AUTO_EN
        auto_cnt_d = '0;
        auto_tick  = 1'b0;
        if (auto_en) begin
            if (auto_cnt_q == AW'(AUTO_DIV - 1)) begin
                // Any button pulse in the same cycle swallows the tick.
                auto_tick = ~(press[0] | press[1]);
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end
        step_up = step_up | auto_tick;
`endif
        if (step_up) begin
            pos_d = (pos_q == PW'(NIBBLES - 1)) ? '0 : pos_q + PW'(1);
        end else if (step_dn) begin
            pos_d = (pos_q == '0) ? PW'(NIBBLES - 1) : pos_q - PW'(1);
        end
    end

    always_comb begin
        refresh_d = refresh_q + REFRESH_BITS'(1);
        digit_d   = digit_q;
        if (&refresh_q) begin
            digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end

        // pos and digit are both below NIBBLES, so one conditional subtract gives the modulo.
        nib_sum  = {1'b0, pos_q} + (PW + 1)'(digit_q);
        nib_full = (nib_sum >= (PW + 1)'(NIBBLES)) ? nib_sum - (PW + 1)'(NIBBLES) : nib_sum;
        nib      = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_full == (PW + 1)'(i)) nib = value[4*i +: 4];
        end

        seg_d = glyph(nib);
        an_d  = ~(DIGITS'(1) << digit_q);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q     <= '0;
            armed_q   <= '0;
            db_cnt_q  <= '0;
            pos_q     <= '0;
            refresh_q <= '0;
            digit_q   <= '0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
`ifdef SCROLL_AUTO_EN
            auto_cnt_q <= '0;
`endif
        end else begin
            lvl_q     <= lvl_d;
            armed_q   <= armed_d;
            db_cnt_q  <= db_cnt_d;
            pos_q     <= pos_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
`ifdef SCROLL_AUTO_EN
            auto_cnt_q <= auto_cnt_d;
`endif
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign pos = pos_q;

endmodule

// File: tb/tb_scroll_hex_disp.sv
// Directed self-checking bench for scroll_hex_disp with small timing parameters;
// expectations for auto-scroll follow `SCROLL_AUTO_EN as compiled.
module tb_scroll_hex_disp;

    localparam int NIBBLES = 8;
    localparam int DIGITS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        btnU, btnD, auto_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [2:0]  pos;

    int n_checks = 0;
    int n_fail   = 0;
    int changes;

    scroll_hex_disp #(
        .NIBBLES(NIBBLES), .DIGITS(DIGITS), .REFRESH_BITS(2),
        .DEBOUNCE_CYCLES(4), .AUTO_DIV(16)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .btnU(btnU), .btnD(btnD),
        .auto_en(auto_en), .seg(seg), .an(an), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a button pattern for n cycles, release, settle; count pos changes throughout.
    task automatic hold(input logic up, input logic dn, input int n, output int chg);
        logic [2:0] prev;
        btnU = up;
        btnD = dn;
        prev = pos;
        chg  = 0;
        for (int i = 0; i < n + 8; i++) begin
            if (i == n) begin
                btnU = 1'b0;
                btnD = 1'b0;
            end
            @(negedge clk);
            if (pos != prev) chg++;
            prev = pos;
        end
    endtask

    // Wait (bounded) for digit k to be driven, then check its glyph.
    task automatic scan(input int k, input logic [6:0] exp, input string tag);
        logic [3:0] want;
        want = ~(4'b0001 << k);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == want) break;
        end
        check({tag, "_an"}, 32'(an), 32'(want));
        check(tag, 32'(seg), 32'(exp));
    endtask

    initial begin
        rst     = 1'b1;
        value   = 32'h24E2C17D;
        btnU    = 1'b0;
        btnD    = 1'b0;
        auto_en = 1'b0;
        cycles(5);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'hF);
        check("rst_pos", 32'(pos), 32'h0);

        rst = 1'b0;
        cycles(1);
        check("first_an",  32'(an),  32'hE);
        check("first_seg", 32'(seg), 32'h21);
        cycles(8);

        hold(1'b1, 1'b0, 10, changes);
        check("up_pos",   32'(pos), 32'd1);
        check("up_pulse", 32'(changes), 32'd1);
        scan(3, 7'h24, "p1_d3");
        scan(2, 7'h46, "p1_d2");
        scan(1, 7'h79, "p1_d1");
        scan(0, 7'h78, "p1_d0");

        hold(1'b0, 1'b1, 10, changes);
        check("dn_pos0", 32'(pos), 32'd0);
        hold(1'b0, 1'b1, 10, changes);
        check("dn_wrap", 32'(pos), 32'd7);
        scan(3, 7'h79, "p7_d3");
        scan(2, 7'h78, "p7_d2");
        scan(1, 7'h21, "p7_d1");
        scan(0, 7'h24, "p7_d0");

        hold(1'b1, 1'b0, 10, changes);
        check("up_wrap", 32'(pos), 32'd0);

        // 3-cycle bursts never meet the 4-cycle stability requirement.
        btnU = 1'b0;
        for (int i = 0; i < 40; i++) begin
            btnU = ((i % 6) < 3);
            @(negedge clk);
        end
        btnU = 1'b0;
        cycles(8);
        check("bounce_pos", 32'(pos), 32'd0);

        hold(1'b1, 1'b1, 10, changes);
        check("both_pos", 32'(pos), 32'd0);
        check("both_chg", 32'(changes), 32'd0);

        // Button held through reset must not fire until released and re-pressed.
        btnU = 1'b1;
        cycles(10);
        rst = 1'b1;
        #1;
        check("async_rst_pos", 32'(pos), 32'd0);
        cycles(3);
        rst = 1'b0;
        cycles(20);
        check("held_rst_pos", 32'(pos), 32'd0);
        btnU = 1'b0;
        cycles(8);
        hold(1'b1, 1'b0, 10, changes);
        check("repress_pos", 32'(pos), 32'd1);
        hold(1'b0, 1'b1, 10, changes);
        check("back_pos0", 32'(pos), 32'd0);

        // Reset in the middle of a debounce window discards the press.
        btnU = 1'b1;
        cycles(4);
        rst = 1'b1;
        btnU = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(12);
        check("mid_db_pos", 32'(pos), 32'd0);

        auto_en = 1'b1;
        cycles(8);
        check("auto_8", 32'(pos), 32'd0);
        cycles(8);
`ifdef SCROLL_AUTO_EN
        check("auto_16", 32'(pos), 32'd1);
`else
        check("auto_16", 32'(pos), 32'd0);
`endif
        cycles(112);
        check("auto_128", 32'(pos), 32'd0);
        cycles(20);
`ifdef SCROLL_AUTO_EN
        check("auto_148", 32'(pos), 32'd1);
`else
        check("auto_148", 32'(pos), 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("auto_rst_pos", 32'(pos), 32'd0);
        cycles(2);
        rst     = 1'b0;
        auto_en = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
